fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 131 +++++++++++++
 tb/tb_fifo_wr_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter feeding a single FIFO write port
module fifo_wr_arb #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      i_wren,
  output logic [DATA_W-1:0]         i_wrdata,
  input  logic                      o_full,
  input  logic                      o_alm_full,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy
);

  localparam int         OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [OW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                wren_q, wren_d;
  logic [DATA_W-1:0]   wrdata_q, wrdata_d;
  logic [N_REQ-1:0]    grant_q, grant_d;

  logic                any_valid;
  logic [OW-1:0]       sel;
  logic                wr_ok;
  logic                accept;
  logic [OW-1:0]       next_ptr;
  logic [DATA_W-1:0]   owner_data;

  // A write already in flight consumes the last free slot when almost full.
  assign wr_ok      = !o_full && !(o_alm_full && wren_q);
  assign accept     = (state_q == BURST) && req_valid[owner_q] && wr_ok;
  assign next_ptr   = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign owner_data = req_data[int'(owner_q)*DATA_W +: DATA_W];

  assign i_wren   = wren_q;
  assign i_wrdata = wrdata_q;
  assign grant    = grant_q;
  assign busy     = (state_q == BURST);

  // Pick the first valid requester at or after rr_ptr, wrapping; scan high-to-low so the nearest wins.
  always_comb begin
    any_valid = 1'b0;
    sel       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx]) begin
        any_valid = 1'b1;
        sel       = OW'(idx);
      end
    end
  end

  // Only the burst owner sees ready, and only when the FIFO can take a beat.
  always_comb begin
    req_ready = '0;
    if ((state_q == BURST) && wr_ok && !reset) req_ready[owner_q] = 1'b1;
  end

  // Next-state, beat counting and FIFO write staging.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    wren_d   = 1'b0;
    wrdata_d = wrdata_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = BURST;
          owner_d = sel;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (accept) begin
          wren_d   = 1'b1;
          wrdata_d = owner_data;
          cnt_d    = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == MAX_CNT) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (!req_valid[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_d[i] = (state_d == BURST) && (owner_d == OW'(i));
    end
  end

  // State and output registers; reset clears everything at once, dropping any staged beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      wren_q   <= 1'b0;
      wrdata_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      wren_q   <= wren_d;
      wrdata_q <= wrdata_d;
      grant_q  <= grant_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - self-checking bench for fifo_wr_arb
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 8;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            i_wren;
  logic [DW-1:0]   i_wrdata;
  logic            o_full;
  logic            o_alm_full;
  logic [N-1:0]    grant;
  logic            busy;

  fifo_wr_arb #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .i_wren(i_wren), .i_wrdata(i_wrdata),
    .o_full(o_full), .o_alm_full(o_alm_full), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [N-1:0]  valid;
    logic          full;
    logic          alm;
    logic [N-1:0]  ready;
    logic          wren;
    logic [DW-1:0] data;
    logic [N-1:0]  grant;
  } vec_t;

  vec_t tbl[17];

  // behavioural model state: owner -1 means no burst in progress
  int          m_owner;
  int          m_ptr;
  int          m_beats;
  logic        m_wren;
  logic [31:0] m_data;
  int          seq[N];
  logic [31:0] d[N];
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = d[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; o_full = 1'b0; o_alm_full = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_owner = -1; m_ptr = 0; m_beats = 0; m_wren = 1'b0; m_data = '0;
    exp_q.delete();
  endtask

  initial begin
    logic [N-1:0] m_ready;
    logic         wr_ok;
    logic         prev_full;
    bit           found;
    int           idx;
    int           p;
    logic [N-1:0] eg;

    reset = 1'b1; req_valid = '0; o_full = 1'b0; o_alm_full = 1'b0;
    for (int i = 0; i < N; i++) begin d[i] = 32'hA000_0000 + 32'(i); seq[i] = 0; end
    drive_data();
    #1;
    chk("rst_wren", {31'b0, i_wren}, 0);
    chk("rst_wrdata", i_wrdata, 0);
    chk("rst_grant", {28'b0, grant}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ready", {28'b0, req_ready}, 0);
    @(negedge clk);
    reset = 1'b0;

    // directed table: single requester burst, almost-full throttling, full stall, wrap
    tbl[0]  = '{4'b0100, 0, 0, 4'b0000, 0, 32'h0,         4'b0000};
    tbl[1]  = '{4'b0100, 0, 0, 4'b0100, 0, 32'h0,         4'b0100};
    tbl[2]  = '{4'b0100, 0, 0, 4'b0100, 1, 32'hA000_0002, 4'b0100};
    tbl[3]  = '{4'b0100, 0, 0, 4'b0100, 1, 32'hA000_0002, 4'b0100};
    tbl[4]  = '{4'b0000, 0, 0, 4'b0100, 1, 32'hA000_0002, 4'b0100};
    tbl[5]  = '{4'b1001, 0, 0, 4'b0000, 0, 32'hA000_0002, 4'b0000};
    tbl[6]  = '{4'b1001, 0, 1, 4'b1000, 0, 32'hA000_0002, 4'b1000};
    tbl[7]  = '{4'b1001, 0, 1, 4'b0000, 1, 32'hA000_0003, 4'b1000};
    tbl[8]  = '{4'b1001, 0, 1, 4'b1000, 0, 32'hA000_0003, 4'b1000};
    tbl[9]  = '{4'b1001, 1, 0, 4'b0000, 1, 32'hA000_0003, 4'b1000};
    tbl[10] = '{4'b1001, 1, 0, 4'b0000, 0, 32'hA000_0003, 4'b1000};
    tbl[11] = '{4'b1001, 0, 0, 4'b1000, 0, 32'hA000_0003, 4'b1000};
    tbl[12] = '{4'b0001, 0, 0, 4'b1000, 1, 32'hA000_0003, 4'b1000};
    tbl[13] = '{4'b0011, 0, 0, 4'b0000, 0, 32'hA000_0003, 4'b0000};
    tbl[14] = '{4'b0011, 0, 0, 4'b0001, 0, 32'hA000_0003, 4'b0001};
    tbl[15] = '{4'b0000, 0, 0, 4'b0001, 1, 32'hA000_0000, 4'b0001};
    tbl[16] = '{4'b0000, 0, 0, 4'b0000, 0, 32'hA000_0000, 4'b0000};
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      req_valid = tbl[c].valid; o_full = tbl[c].full; o_alm_full = tbl[c].alm;
      #1;
      chk($sformatf("tbl%0d_ready", c), {28'b0, req_ready}, {28'b0, tbl[c].ready});
      chk($sformatf("tbl%0d_wren", c), {31'b0, i_wren}, {31'b0, tbl[c].wren});
      chk($sformatf("tbl%0d_data", c), i_wrdata, tbl[c].data);
      chk($sformatf("tbl%0d_grant", c), {28'b0, grant}, {28'b0, tbl[c].grant});
      chk($sformatf("tbl%0d_busy", c), {31'b0, busy}, {31'b0, (tbl[c].grant != 0)});
    end

    // fairness: all valid, FIFO never full -> 8-beat bursts rotating with one idle cycle between
    do_reset();
    for (int c = 0; c < 38; c++) begin
      @(negedge clk);
      req_valid = '1;
      #1;
      p  = c % 9;
      eg = (p == 0) ? 4'b0000 : 4'(1 << ((c / 9) % N));
      chk($sformatf("fair%0d_grant", c), {28'b0, grant}, {28'b0, eg});
      chk($sformatf("fair%0d_ready", c), {28'b0, req_ready}, {28'b0, eg});
      chk($sformatf("fair%0d_wren", c), {31'b0, i_wren}, {31'b0, (c > 0) && ((c - 1) % 9 != 0)});
      if ((c > 0) && ((c - 1) % 9 != 0))
        chk($sformatf("fair%0d_data", c), i_wrdata, d[((c - 1) / 9) % N]);
    end

    // reset in the middle of a burst from requester 1
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 4'b0010;
    end
    #1;
    chk("mid_grant_before", {28'b0, grant}, 4'b0010);
    @(negedge clk);
    req_valid = 4'b0011;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_wren", {31'b0, i_wren}, 0);
    chk("mid_rst_data", i_wrdata, 0);
    chk("mid_rst_grant", {28'b0, grant}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_ready", {28'b0, req_ready}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_idle", {28'b0, grant}, 0);
    @(negedge clk);
    #1;
    chk("post_rst_grant0", {28'b0, grant}, 4'b0001);

    // randomized run against the behavioural model with an in-order write scoreboard
    do_reset();
    for (int i = 0; i < N; i++) begin seq[i] = 0; d[i] = (32'(i) << 28); end
    prev_full = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 9) < 7);
      o_full     = ($urandom_range(0, 9) < 2);
      o_alm_full = ($urandom_range(0, 9) < 3);
      drive_data();
      #1;
      wr_ok   = !o_full && !(o_alm_full && m_wren);
      m_ready = '0;
      if (m_owner >= 0 && wr_ok) m_ready[m_owner] = 1'b1;
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      chk("rnd_ready", {28'b0, req_ready}, {28'b0, m_ready});
      chk("rnd_grant", {28'b0, grant}, {28'b0, eg});
      chk("rnd_busy", {31'b0, busy}, {31'b0, (m_owner >= 0)});
      chk("rnd_wren", {31'b0, i_wren}, {31'b0, m_wren});
      chk("rnd_onehot", {31'b0, $onehot0(grant)}, 1);
      if (prev_full) chk("rnd_no_write_full", {31'b0, i_wren}, 0);
      if (i_wren) begin
        if (exp_q.size() == 0) chk("rnd_unexpected_write", i_wrdata, 32'hDEAD_BEEF);
        else chk("rnd_wrdata", i_wrdata, exp_q.pop_front());
      end
      prev_full = o_full;
      m_wren = 1'b0;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!found && req_valid[idx]) begin
            found = 1'b1; m_owner = idx; m_beats = 0;
          end
        end
      end else if (req_valid[m_owner] && wr_ok) begin
        m_wren = 1'b1;
        m_data = d[m_owner];
        exp_q.push_back(d[m_owner]);
        seq[m_owner]++;
        d[m_owner] = (32'(m_owner) << 28) | 32'(seq[m_owner]);
        m_beats++;
        if (m_beats == MB) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
      end else if (!req_valid[m_owner]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1;
      end
    end
    @(negedge clk);
    req_valid = '0; o_full = 1'b0; o_alm_full = 1'b0;
    #1;
    if (i_wren && exp_q.size() > 0) chk("rnd_last_wrdata", i_wrdata, exp_q.pop_front());
    chk("rnd_queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
